// File: rtl/pwm_duty_monitor_if.sv
// Measurement record bus of pwm_duty_monitor: show-ahead head record, handshake and status.
interface pwm_duty_monitor_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 9
);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] meas_high;
   logic [CNT_W-1:0] meas_len;
   logic             meas_valid;
   logic             meas_ready;
   logic [LW-1:0]    meas_level;
   logic             overflow;

   modport master (
      output meas_high,
      output meas_len,
      output meas_valid,
      output meas_level,
      output overflow,
      input  meas_ready
   );

   modport slave (
      input  meas_high,
      input  meas_len,
      input  meas_valid,
      input  meas_level,
      input  overflow,
      output meas_ready
   );
endinterface

// File: rtl/pwm_duty_monitor.sv
// Measures high-time and length of each PWM period and queues {high,len} records in a
// show-ahead FIFO with a sticky overflow flag.
module pwm_duty_monitor #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 9
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               pwm_en_i,
   input  logic               pwm_period_i,
   input  logic               pwm_out_i,
   pwm_duty_monitor_if.master meas
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned RW = 2 * CNT_W;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StSync    = 2'd1;
   localparam logic [1:0] StMeasure = 2'd2;

   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [LW-1:0]    LvlOne  = LW'(1);
   localparam logic [LW-1:0]    LvlFull = LW'(DEPTH);
   localparam logic [AW-1:0]    PtrOne  = AW'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             push;

   logic [RW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             valid, full, pop, do_push;
   logic [RW-1:0]    head;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      high_d  = high_q;
      push    = 1'b0;
      // Losing enable abandons the current period, even on a pulse cycle.
      if (!pwm_en_i) begin
         state_d = StIdle;
         len_d   = '0;
         high_d  = '0;
      end else begin
         case (state_q)
            StIdle: state_d = StSync;
            StSync: begin
               if (pwm_period_i) begin
                  state_d = StMeasure;
                  len_d   = CntOne;
                  high_d  = CNT_W'(pwm_out_i);
               end
            end
            StMeasure: begin
               if (pwm_period_i) begin
                  push   = 1'b1;
                  len_d  = CntOne;
                  high_d = CNT_W'(pwm_out_i);
               end else begin
                  len_d  = (len_q == CntMax) ? len_q : len_q + CntOne;
                  high_d = (pwm_out_i && (high_q != CntMax)) ? high_q + CntOne : high_q;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign valid   = (count_q != '0);
   assign full    = (count_q == LvlFull);
   assign pop     = valid & meas.meas_ready;
   // A full FIFO still accepts a record when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign head    = mem_q[rptr_q];

   always_comb begin
      wptr_d  = do_push ? wptr_q + PtrOne : wptr_q;
      rptr_d  = pop ? rptr_q + PtrOne : rptr_q;
      ovf_d   = ovf_q | (push & ~do_push);
      count_d = count_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + LvlOne;
         2'b01:   count_d = count_q - LvlOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         len_q   <= '0;
         high_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         high_q  <= high_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && do_push) begin
         mem_q[wptr_q] <= {high_q, len_q};
      end
   end

   // Record fields read as zero while the FIFO is empty.
   assign meas.meas_high  = valid ? head[RW-1:CNT_W] : '0;
   assign meas.meas_len   = valid ? head[CNT_W-1:0] : '0;
   assign meas.meas_valid = valid;
   assign meas.meas_level = count_q;
   assign meas.overflow   = ovf_q;
endmodule

// File: doc/pwm_duty_monitor.md
PWM_DUTY_MONITOR -- requirements
Module: pwm_duty_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 9, width of the measurement counters (covers 256-cycle periods).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 pwm_en  in  1  enable of the upstream PWM unit; measurement runs only while high.
REQ-006 pwm_period  in  1  one-cycle pulse marking the first cycle of each PWM period.
REQ-007 pwm_out  in  1  PWM waveform under measurement.
REQ-008 meas_high  out  CNT_W  high-cycle count of the head record.
REQ-009 meas_len  out  CNT_W  period length in cycles of the head record.
REQ-010 meas_valid  out  1  head record present (FIFO not empty).
REQ-011 meas_ready  in  1  consumer accepts the head record.
REQ-012 meas_level  out  $clog2(DEPTH+1)  records currently held.
REQ-013 overflow  out  1  sticky: a completed record was dropped.

Function
REQ-014 SHALL implement states IDLE, SYNC, MEASURE.
REQ-015 IDLE: pwm_en=1 -> SYNC; otherwise stay.
REQ-016 SYNC: wait for pwm_period=1; any partial period before it is discarded; on pulse -> MEASURE with len=1, high=pwm_out of that cycle.
REQ-017 MEASURE, no pulse: len+=1, high+=pwm_out each cycle; both saturate at 2^CNT_W-1, no wrap.
REQ-018 MEASURE, pulse: push {high,len} of the completed period (excluding the pulse cycle) and restart the counters with len=1, high=pwm_out of the pulse cycle.
REQ-019 pwm_en=0 in any state -> IDLE next cycle; partial period discarded; FIFO contents, meas_level, overflow retained.
REQ-020 pwm_en falling in the same cycle as pwm_period: no push, -> IDLE.
REQ-021 Pushed record SHALL appear at the outputs (meas_valid=1 if previously empty) the cycle after the terminating pulse.
REQ-022 FIFO SHALL be show-ahead; pop occurs on meas_valid & meas_ready.
REQ-023 meas_high/meas_len SHALL stay stable while meas_valid=1 and meas_ready=0.
REQ-024 meas_ready with meas_valid=0 SHALL be ignored.
REQ-025 Push when full without simultaneous pop: record dropped, overflow set, held until reset.
REQ-026 Push and pop in the same cycle when full: both performed, no overflow, level unchanged.
REQ-027 Push and pop in the same cycle when not empty: level unchanged, order preserved.
REQ-028 Records SHALL leave in push order; pointers wrap modulo DEPTH.

Reset
REQ-029 On reset: state=IDLE, counters=0, FIFO empty, meas_valid=0, meas_level=0, overflow=0, meas_high=0, meas_len=0.
REQ-030 Reset SHALL take priority over all other inputs, including mid-period and mid-handshake; the in-progress measurement and all queued records are lost.

Verification
REQ-031 pwm_en=1, pulse every 10 cycles, pwm_out high for 3 cycles after each pulse, meas_ready=1 -> records {3,10} each, meas_valid 1 cycle after each pulse from the second.
REQ-032 Enable mid-period (4 cycles before the first pulse) -> no record for the partial period; first record {3,10}.
REQ-033 meas_ready=0, 5 periods {3,10}, DEPTH=4 -> meas_level=4, overflow=1 after the 5th completion; draining yields exactly 4 records.
REQ-034 Full FIFO, meas_ready=1 in the push cycle -> no overflow, level stays 4, order preserved.
REQ-035 Pulse period 600 cycles, pwm_out constant 1 -> record {511,511} (saturated).
REQ-036 pwm_en=0 mid-period, then reset with 2 records queued -> no partial record; after reset meas_valid=0, meas_level=0, overflow=0.
